// File: rtl/digit_pkg.sv
// Shared types and helpers for the multi-digit up/down counter.
package digit_pkg;

  typedef logic [3:0] digit_t;

  localparam int RADIX_BCD = 10;
  localparam int RADIX_HEX = 16;

  // A loaded value that is not a legal digit in the active radix becomes the largest legal digit.
  function automatic digit_t clamp_digit(digit_t value, int radix);
    digit_t result;
    if (int'(value) >= radix) begin
      result = digit_t'(radix - 1);
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/digit_cell.sv
// Combinational next-value logic for one counter digit with carry/borrow in and out.
module digit_cell
  import digit_pkg::*;
(
  input  digit_t     digit_i,
  input  logic       up_i,
  input  logic       step_i,
  input  logic [4:0] radix_i,
  output digit_t     digit_o,
  output logic       step_o
);

  digit_t max_s;

  // Largest legal digit value in the active radix.
  assign max_s = digit_t'(radix_i - 5'd1);

  // Increment/decrement when a step arrives; roll over and pass the step on at the ends of the range.
  always_comb begin
    digit_o = digit_i;
    step_o  = 1'b0;
    if (!step_i) begin
      digit_o = digit_i;
      step_o  = 1'b0;
    end else if (up_i) begin
      if (digit_i >= max_s) begin
        digit_o = 4'd0;
        step_o  = 1'b1;
      end else begin
        digit_o = digit_i + 4'd1;
        step_o  = 1'b0;
      end
    end else begin
      if (digit_i == 4'd0) begin
        digit_o = max_s;
        step_o  = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
        step_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/digit_counter.sv
// Multi-digit BCD/hex up/down counter with prescaler, clear, load and wrap detection.
module digit_counter
  import digit_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int RADIX    = 10,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_up,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_load_value,
  output logic [4*N_DIGITS-1:0] o_digits,
  output logic                  o_tick,
  output logic                  o_wrap
);

  // A TICK_DIV of 1 still needs a one-bit prescaler register.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
  localparam logic [4:0]    RADIX_W  = 5'(RADIX);

  if ((RADIX != RADIX_BCD) && (RADIX != RADIX_HEX)) begin : g_radix_illegal
    $error("digit_counter: RADIX must be 10 or 16");
  end
  if ((N_DIGITS < 1) || (N_DIGITS > 8)) begin : g_digits_illegal
    $error("digit_counter: N_DIGITS must be 1..8");
  end
  if (TICK_DIV < 1) begin : g_div_illegal
    $error("digit_counter: TICK_DIV must be >= 1");
  end

  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [4*N_DIGITS-1:0] cell_next_s;
  logic [N_DIGITS:0]     carry_s;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic                  step_s;

  // A step is due on the enabled cycle where the prescaler sits at its last count.
  assign step_s     = i_enable && (presc_q == PS_LAST);
  assign carry_s[0] = step_s;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_cell
    digit_cell u_cell (
      .digit_i (digits_q[4*k +: 4]),
      .up_i    (i_up),
      .step_i  (carry_s[k]),
      .radix_i (RADIX_W),
      .digit_o (cell_next_s[4*k +: 4]),
      .step_o  (carry_s[k+1])
    );
  end

  // Prescaler next state: cleared by clear/load, free-runs while enabled, holds otherwise.
  always_comb begin
    presc_d = presc_q;
    if (i_clear || i_load) begin
      presc_d = '0;
    end else if (i_enable) begin
      if (step_s) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Digit and pulse next state with clear > load > step > hold priority.
  always_comb begin
    digits_d = digits_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (i_clear) begin
      digits_d = {(4*N_DIGITS){1'b0}};
    end else if (i_load) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        digits_d[4*k +: 4] = clamp_digit(i_load_value[4*k +: 4], RADIX);
      end
    end else if (step_s) begin
      digits_d = cell_next_s;
      tick_d   = 1'b1;
      wrap_d   = carry_s[N_DIGITS];
    end else begin
      digits_d = digits_q;
    end
  end

  // State registers; everything returns to zero on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      digits_q <= {(4*N_DIGITS){1'b0}};
      presc_q  <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign o_digits = digits_q;
  assign o_tick   = tick_q;
  assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_digit_counter.sv
// Directed bench: BCD/TICK_DIV=4 (table-driven), hex/TICK_DIV=4 and BCD/TICK_DIV=1 (hand sequences).
module tb_digit_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, up, clear, load;
  logic [15:0] load_value;

  logic [15:0] dig_a, dig_h, dig_f;
  logic        tick_a, tick_h, tick_f;
  logic        wrap_a, wrap_h, wrap_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_counter #(.N_DIGITS(4), .RADIX(10), .TICK_DIV(4)) u_dut_bcd (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_up(up), .i_clear(clear),
    .i_load(load), .i_load_value(load_value), .o_digits(dig_a), .o_tick(tick_a), .o_wrap(wrap_a));

  digit_counter #(.N_DIGITS(4), .RADIX(16), .TICK_DIV(4)) u_dut_hex (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_up(up), .i_clear(clear),
    .i_load(load), .i_load_value(load_value), .o_digits(dig_h), .o_tick(tick_h), .o_wrap(wrap_h));

  digit_counter #(.N_DIGITS(4), .RADIX(10), .TICK_DIV(1)) u_dut_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_up(up), .i_clear(clear),
    .i_load(load), .i_load_value(load_value), .o_digits(dig_f), .o_tick(tick_f), .o_wrap(wrap_f));

  typedef struct {
    logic        clr;
    logic        ld;
    logic        en;
    logic        u;
    logic [15:0] lv;
    int          rep;
    logic [15:0] exp_dig;
    logic        exp_tick;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input logic l, input logic e, input logic u_i,
                     input logic [15:0] v, input int r, input logic [15:0] d,
                     input logic t, input logic w);
    vec_t x;
    x.clr = c; x.ld = l; x.en = e; x.u = u_i; x.lv = v; x.rep = r;
    x.exp_dig = d; x.exp_tick = t; x.exp_wrap = w;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic u_i,
                       input logic [15:0] v);
    clear = c; load = l; enable = e; up = u_i; load_value = v;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    #12;
    check("reset_digits", dig_a, 16'h0000);
    check("reset_tick", {15'd0, tick_a}, 16'h0000);
    check("reset_wrap", {15'd0, wrap_a}, 16'h0000);
    cyc();
    rst_n = 1'b1;

    // clr ld en up load_value rep  exp_digits tick wrap
    add(1'b0, 1'b1, 1'b0, 1'b1, 16'h0099, 1,  16'h0099, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3,  16'h0099, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1,  16'h0100, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 10, 16'h0100, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1,  16'h9999, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3,  16'h9999, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1,  16'h0000, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3,  16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1,  16'h9999, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3,  16'h9999, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1,  16'h9998, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 16'hF00C, 1,  16'h9009, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 16'h123C, 1,  16'h1239, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3,  16'h1239, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 1,  16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 3,  16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1,  16'h0001, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3,  16'h0001, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1,  16'h0002, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2,  16'h0002, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].u, vecs[i].lv);
      for (int r = 0; r < vecs[i].rep; r++) begin
        cyc();
        check($sformatf("vec%0d_%0d_digits", i, r), dig_a, vecs[i].exp_dig);
        check($sformatf("vec%0d_%0d_tick", i, r), {15'd0, tick_a}, {15'd0, vecs[i].exp_tick});
        check($sformatf("vec%0d_%0d_wrap", i, r), {15'd0, wrap_a}, {15'd0, vecs[i].exp_wrap});
      end
    end

    // Reset in the middle of a prescale period discards digits and prescaler.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000); cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0123); cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); cyc(); cyc();
    check("midrst_pre_digits", dig_a, 16'h0123);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_digits", dig_a, 16'h0000);
    check("midrst_async_tick", {15'd0, tick_a}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cyc();
      check($sformatf("midrst_wait%0d_tick", r), {15'd0, tick_a}, 16'h0000);
      check($sformatf("midrst_wait%0d_digits", r), dig_a, 16'h0000);
    end
    cyc();
    check("midrst_first_tick", {15'd0, tick_a}, 16'h0001);
    check("midrst_first_digits", dig_a, 16'h0001);

    // Hex radix: 00FF up carries into 0100; 0000 down wraps to FFFF.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF); cyc();
    check("hex_load_noclamp", dig_h, 16'h00FF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc(); cyc(); cyc();
    check("hex_pre_step", dig_h, 16'h00FF);
    cyc();
    check("hex_up_digits", dig_h, 16'h0100);
    check("hex_up_tick", {15'd0, tick_h}, 16'h0001);
    check("hex_up_wrap", {15'd0, wrap_h}, 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc(); cyc(); cyc(); cyc();
    check("hex_down_digits", dig_h, 16'hFFFF);
    check("hex_down_tick", {15'd0, tick_h}, 16'h0001);
    check("hex_down_wrap", {15'd0, wrap_h}, 16'h0001);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); cyc();
    check("hex_wrap_one_cycle", {15'd0, wrap_h}, 16'h0000);

    // TICK_DIV=1: a step on every enabled cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000); cyc();
    check("fast_cleared", dig_f, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    for (int r = 0; r < 12; r++) begin
      cyc();
      check($sformatf("fast_tick%0d", r), {15'd0, tick_f}, 16'h0001);
    end
    check("fast_digits", dig_f, 16'h0012);
    check("fast_wrap", {15'd0, wrap_f}, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); cyc();
    check("fast_idle_tick", {15'd0, tick_f}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_counter.md
Name: digit_counter

Overview:
Multi-digit up/down counter that produces the 4-bit digit codes consumed by the seven-segment decoders, one decoder per digit. A built-in prescaler turns the system clock into a step rate. Digits count in BCD (radix 10) or hex (radix 16) with ripple carry/borrow between digits. It supports synchronous clear and parallel load, and sits directly upstream of the per-digit seven-segment decoders in the board top level.

Parameters:
N_DIGITS, 4, number of cascaded digits (1..8)
RADIX, 10, digit modulus; only 10 or 16 legal (elaboration-time assertion)
TICK_DIV, 50_000_000, clock cycles per count step while enabled (>=1)

Ports:
i_clk  input  1  system clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  prescaler runs while high, holds while low
i_up  input  1  1 = count up, 0 = count down; sampled on the step cycle
i_clear  input  1  synchronous clear of digits and prescaler
i_load  input  1  synchronous parallel load
i_load_value  input  4*N_DIGITS  load digits, digit k at [4k+3:4k], digit 0 = least significant
o_digits  output  4*N_DIGITS  current digits, same packing; each slice feeds one decoder
o_tick  output  1  registered, 1-cycle pulse on every count step
o_wrap  output  1  registered, 1-cycle pulse when the whole counter wraps (max->0 up, 0->max down)

Behaviour:
- Reset (i_rst_n low, asynchronous): o_digits=0, prescaler=0, o_tick=0, o_wrap=0. Reset mid-count discards all state. Deassertion is expected synchronous to i_clk.
- Priority each cycle: i_clear > i_load > step > hold.
- i_clear: digits=0, prescaler=0, o_tick=0, o_wrap=0 next cycle, regardless of i_enable.
- i_load without i_clear: each digit takes its i_load_value slice; prescaler=0; no tick/wrap. Any slice >= RADIX is clamped to RADIX-1 (e.g. 4'hC loads as 9 when RADIX=10).
- Prescaler: width $clog2(TICK_DIV) (min 1).
  - While i_enable=1, it increments each cycle.
  - At TICK_DIV-1 a step occurs and the prescaler returns to 0.
  - While i_enable=0 it holds its value; no step occurs.
  - TICK_DIV=1 gives a step on every enabled cycle.
- Step: digits update on that clock edge. o_tick=1 and the new o_digits are both visible in the following cycle.
- Up step: digit 0 increments. A digit at RADIX-1 becomes 0 and carries into the next digit; other digits hold.
- Down step: digit 0 decrements. A digit at 0 becomes RADIX-1 and borrows from the next digit.
- Carry/borrow is combinational ripple inside one cycle; all digits update together, with no intermediate values visible.
- Wrap: a carry/borrow out of the top digit sets o_wrap=1 for exactly the cycle o_tick=1 (all-max -> all-zero up, all-zero -> all-max down).
- i_up is sampled only on the step cycle; changing it between steps has no other effect.
- o_tick and o_wrap are 0 in every cycle without a step.

Decomposition:
- Package digit_pkg:
  - typedef digit_t (logic [3:0])
  - constants RADIX_BCD=10 and RADIX_HEX=16
  - function clamp_digit(digit_t value, int radix)
- Sub-module digit_cell:
  - Purely combinational next-value logic for one digit.
  - Inputs: digit_t, up, step_in (carry/borrow in), radix.
  - Outputs: next digit_t, step_out.
  - digit_counter instantiates N_DIGITS cells in a chain and holds all registers.

Test Plan:
- Bench uses TICK_DIV=4, N_DIGITS=4, RADIX=10 unless stated.
- Reset mid-count: digits=0123, enable, pulse i_rst_n low between steps -> o_digits=0000, o_tick=0 immediately; first tick exactly 4 enabled cycles after release.
- Up with BCD carry: load 0099, i_up=1, enable -> after 4 cycles o_digits=0100, o_tick=1 for one cycle, o_wrap=0; hold i_enable low 10 cycles -> value stays 0100, no tick.
- Wrap up and down: load 9999, up -> 0000 with o_tick=o_wrap=1 same cycle; then i_up=0 -> 9999 with o_wrap=1.
- Hex mode (RADIX=16): load 00FF, up -> 0100; load 0000, down -> FFFF with o_wrap=1.
- Priority and clamp: i_clear, i_load and a due step in the same cycle -> 0000, prescaler 0, no tick; load 4'hC in digit 0 at RADIX=10 -> digit 0 reads 9.
- TICK_DIV=1: enable 12 cycles from 0000 up -> o_tick high every cycle, o_digits=0012.
